// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO peripheral: LED outputs with byte-lane and toggle writes, debounced
// button inputs, and per-button edge-selectable sticky interrupts with one level IRQ.
module wb_gpio_irq #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h3000_0000,
    parameter int          NUM_LEDS        = 8,
    parameter int          NUM_BUTTONS     = 3,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_wb_cyc,
    input  logic                   i_wb_stb,
    input  logic                   i_wb_we,
    input  logic [3:0]             i_wb_sel,
    input  logic [31:0]            i_wb_addr,
    input  logic [31:0]            i_wb_data,
    output logic                   o_wb_ack,
    output logic                   o_wb_stall,
    output logic [31:0]            o_wb_data,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_LEDS-1:0]    leds,
    output logic                   o_irq
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]    LED_MASK = 32'((64'd1 << NUM_LEDS) - 64'd1);
    localparam logic [31:0]    BTN_MASK = 32'((64'd1 << NUM_BUTTONS) - 64'd1);

    logic [31:0]            offset;
    logic [31:0]            lane_mask;
    logic [31:0]            wdata;
    logic [31:0]            rdata;
    logic                   hit;
    logic                   req;
    logic                   wr_en;
    logic [31:0]            led_q;
    logic [31:0]            en_q;
    logic [31:0]            edge_sel_q;
    logic [31:0]            status_q;
    logic [31:0]            led_next;
    logic [31:0]            status_clr;
    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [NUM_BUTTONS-1:0] stable;
    logic [NUM_BUTTONS-1:0] update;
    logic [NUM_BUTTONS-1:0] event_set;
    logic [CW-1:0]          cnt [NUM_BUTTONS];

    // Addresses below the base wrap to large offsets and so fall outside the window.
    assign offset     = i_wb_addr - BASE_ADDRESS;
    assign hit        = (offset[1:0] == 2'b00) && (offset <= 32'h14);
    assign req        = i_wb_cyc && i_wb_stb && hit;
    assign wr_en      = req && i_wb_we;
    assign lane_mask  = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign wdata      = i_wb_data & lane_mask;
    assign o_wb_stall = 1'b0;
    assign leds       = led_q[NUM_LEDS-1:0];

    always_comb begin
        update    = '0;
        event_set = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            update[i]    = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
            event_set[i] = update[i] && (sync2[i] == edge_sel_q[i]);
        end
    end

    always_comb begin
        led_next   = led_q;
        status_clr = '0;
        rdata      = '0;
        if (wr_en) begin
            case (offset[4:2])
                3'd0:    led_next = (led_q & ~lane_mask) | wdata;
                3'd1:    led_next = led_q ^ wdata;
                3'd5:    status_clr = wdata;
                default: ;
            endcase
        end
        case (offset[4:2])
            3'd0:    rdata = led_q;
            3'd2:    rdata = 32'(stable);
            3'd3:    rdata = en_q;
            3'd4:    rdata = edge_sel_q;
            3'd5:    rdata = status_q;
            default: rdata = '0;
        endcase
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Event set is OR-ed after the clear so a coincident event survives the W1C.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led_q      <= '0;
            en_q       <= '0;
            edge_sel_q <= BTN_MASK;
            status_q   <= '0;
            o_wb_ack   <= 1'b0;
            o_wb_data  <= '0;
            o_irq      <= 1'b0;
        end else begin
            o_wb_ack <= req;
            if (req && !i_wb_we) o_wb_data <= rdata;
            led_q <= led_next & LED_MASK;
            if (wr_en && offset[4:2] == 3'd3) en_q <= ((en_q & ~lane_mask) | wdata) & BTN_MASK;
            if (wr_en && offset[4:2] == 3'd4) edge_sel_q <= ((edge_sel_q & ~lane_mask) | wdata) & BTN_MASK;
            status_q <= ((status_q & ~status_clr) | 32'(event_set)) & BTN_MASK;
            o_irq    <= |(status_q & en_q);
        end
    end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq: directed vector table, hand-written timing
// sequences, then randomized traffic compared against a behavioural model.
module tb_wb_gpio_irq;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam int          NL       = 8;
    localparam int          NB       = 3;
    localparam int          D        = 16;
    localparam logic [31:0] LED_MASK = 32'h0000_00FF;
    localparam logic [31:0] BTN_MASK = 32'h0000_0007;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   addr, wdata;
    logic          ack, stall;
    logic [31:0]   rdata;
    logic [NB-1:0] buttons;
    logic [NL-1:0] leds;
    logic          irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_gpio_irq #(
        .BASE_ADDRESS(BASE), .NUM_LEDS(NL), .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_sel(sel),
        .i_wb_addr(addr), .i_wb_data(wdata),
        .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdata),
        .buttons(buttons), .leds(leds), .o_irq(irq)
    );

    // Reference model: a button flips once its raw value has been the opposite of the
    // accepted value for the whole D-cycle window seen through the 2-cycle synchroniser.
    logic [31:0]   m_leds, m_en, m_edge, m_status, m_rdata, m_off, m_data, m_clr;
    logic [NB-1:0] m_stable, m_ev;
    logic [NB-1:0] hist [0:D+1];
    logic          m_ack, m_irq, m_irq_n, m_req, m_flip;

    function automatic logic [31:0] lanes(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int k = 0; k < 4; k++) if (s[k]) m[8*k +: 8] = 8'hFF;
        return m;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_leds = '0; m_en = '0; m_edge = BTN_MASK; m_status = '0; m_stable = '0;
            m_ack = 1'b0; m_rdata = '0; m_irq = 1'b0;
            for (int k = 0; k <= D + 1; k++) hist[k] = '0;
        end else begin
            m_off   = addr - BASE;
            m_req   = cyc && stb && (m_off <= 32'h14) && (m_off % 4 == 0);
            m_irq_n = |(m_status & m_en);
            if (m_req && !we) begin
                case (m_off)
                    32'h00:  m_rdata = m_leds;
                    32'h08:  m_rdata = 32'(m_stable);
                    32'h0C:  m_rdata = m_en;
                    32'h10:  m_rdata = m_edge;
                    32'h14:  m_rdata = m_status;
                    default: m_rdata = '0;
                endcase
            end
            for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = buttons;
            m_ev = '0;
            for (int b = 0; b < NB; b++) begin
                m_flip = 1'b1;
                for (int k = 2; k <= D + 1; k++) if (hist[k][b] == m_stable[b]) m_flip = 1'b0;
                if (m_flip) begin
                    m_stable[b] = ~m_stable[b];
                    if (m_stable[b] == m_edge[b]) m_ev[b] = 1'b1;
                end
            end
            m_data = wdata & lanes(sel);
            m_clr  = '0;
            if (m_req && we) begin
                case (m_off)
                    32'h00:  m_leds = ((m_leds & ~lanes(sel)) | m_data) & LED_MASK;
                    32'h04:  m_leds = (m_leds ^ m_data) & LED_MASK;
                    32'h0C:  m_en   = ((m_en & ~lanes(sel)) | m_data) & BTN_MASK;
                    32'h10:  m_edge = ((m_edge & ~lanes(sel)) | m_data) & BTN_MASK;
                    32'h14:  m_clr  = m_data;
                    default: ;
                endcase
            end
            m_status = ((m_status & ~m_clr) | 32'(m_ev)) & BTN_MASK;
            m_ack    = m_req;
            m_irq    = m_irq_n;
        end
    end

    typedef struct {
        logic        cyc;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] off;
        logic [31:0] data;
        logic        exp_ack;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_leds;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic s, input logic w, input logic [3:0] sl,
                                 input logic [31:0] a, input logic [31:0] d);
        cyc = c; stb = s; we = w; sel = sl; addr = a; wdata = d;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busWrite(input logic [31:0] off, input logic [31:0] d, input logic [3:0] sl, input string name);
        applyStimulus(1'b1, 1'b1, 1'b1, sl, BASE + off, d);
        @(negedge clk);
        checkOutput({name, " ack"}, 32'(ack), 32'd1);
        idle();
    endtask

    task automatic busRead(input logic [31:0] off, input logic [31:0] expv, input string name);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, BASE + off, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput({name, " ack"}, 32'(ack), 32'd1);
        checkOutput(name, rdata, expv);
        idle();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'hF, 32'h00, 32'h0,         1'b1, 32'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 4'hF, 32'h04, 32'h0,         1'b1, 32'h00, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 4'hF, 32'h08, 32'h0,         1'b1, 32'h00, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 4'hF, 32'h0C, 32'h0,         1'b1, 32'h00, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 4'hF, 32'h10, 32'h0,         1'b1, 32'h07, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 4'hF, 32'h14, 32'h0,         1'b1, 32'h00, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 4'h1, 32'h00, 32'hA5,        1'b1, 32'h00, 8'hA5};
        vecs[7]  = '{1'b1, 1'b1, 4'h1, 32'h04, 32'h0F,        1'b1, 32'h00, 8'hAA};
        vecs[8]  = '{1'b1, 1'b1, 4'h2, 32'h00, 32'hFF,        1'b1, 32'h00, 8'hAA};
        vecs[9]  = '{1'b1, 1'b0, 4'hF, 32'h00, 32'h0,         1'b1, 32'hAA, 8'hAA};
        vecs[10] = '{1'b1, 1'b1, 4'hF, 32'h18, 32'h0,         1'b0, 32'hAA, 8'hAA};
        vecs[11] = '{1'b1, 1'b1, 4'hF, 32'h02, 32'h0,         1'b0, 32'hAA, 8'hAA};
        vecs[12] = '{1'b1, 1'b0, 4'hF, 32'h18, 32'h0,         1'b0, 32'hAA, 8'hAA};
        vecs[13] = '{1'b0, 1'b1, 4'h1, 32'h00, 32'h55,        1'b0, 32'hAA, 8'hAA};
        vecs[14] = '{1'b1, 1'b1, 4'hE, 32'h04, 32'hFFFF_FF00, 1'b1, 32'hAA, 8'hAA};
        vecs[15] = '{1'b1, 1'b0, 4'hF, 32'h04, 32'h0,         1'b1, 32'h00, 8'hAA};

        reset_n = 1'b0;
        buttons = '0;
        idle();
        step(3);
        reset_n = 1'b1;
        checkOutput("reset leds", 32'(leds), 32'h0);
        checkOutput("reset irq", 32'(irq), 32'h0);
        checkOutput("reset ack", 32'(ack), 32'h0);
        checkOutput("stall", 32'(stall), 32'h0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].cyc, 1'b1, vecs[i].we, vecs[i].sel, BASE + vecs[i].off, vecs[i].data);
            @(negedge clk);
            checkOutput($sformatf("vec%0d ack", i), 32'(ack), 32'(vecs[i].exp_ack));
            checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d leds", i), 32'(leds), 32'(vecs[i].exp_leds));
            idle();
        end

        // Short glitch must be filtered out completely.
        buttons = 3'b010;
        step(10);
        buttons = '0;
        step(30);
        busRead(32'h08, 32'h0, "glitch button");
        busRead(32'h14, 32'h0, "glitch status");

        // Rising press: accepted 18 cycles after the raw edge, IRQ one cycle later.
        busWrite(32'h0C, 32'h2, 4'hF, "enable");
        buttons = 3'b010;
        step(17);
        checkOutput("press irq T+17", 32'(irq), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, BASE + 32'h08, 32'h0);
        @(negedge clk);
        checkOutput("press ack T+18", 32'(ack), 32'h1);
        checkOutput("press button T+17", rdata, 32'h0);
        checkOutput("press irq T+18", 32'(irq), 32'h0);
        @(negedge clk);
        checkOutput("press ack T+19", 32'(ack), 32'h1);
        checkOutput("press button T+18", rdata, 32'h2);
        checkOutput("press irq T+19", 32'(irq), 32'h1);
        idle();
        busRead(32'h14, 32'h2, "press status");
        busWrite(32'h14, 32'h2, 4'hF, "w1c press");
        checkOutput("w1c irq N+1", 32'(irq), 32'h1);
        step(1);
        checkOutput("w1c irq N+2", 32'(irq), 32'h0);
        buttons = '0;
        step(25);
        busRead(32'h14, 32'h0, "rising-mode release status");

        // Falling-edge mode: only the release records an event.
        busWrite(32'h10, 32'h0, 4'hF, "edge falling");
        buttons = 3'b010;
        step(25);
        busRead(32'h14, 32'h0, "falling-mode press status");
        checkOutput("falling-mode press irq", 32'(irq), 32'h0);
        buttons = '0;
        step(18);
        checkOutput("release irq T+18", 32'(irq), 32'h0);
        step(1);
        checkOutput("release irq T+19", 32'(irq), 32'h1);
        busRead(32'h14, 32'h2, "release status");
        busWrite(32'h14, 32'h2, 4'h2, "w1c wrong lane");
        busRead(32'h14, 32'h2, "status after wrong-lane w1c");
        busWrite(32'h14, 32'h2, 4'h1, "w1c release");
        checkOutput("release w1c irq N+1", 32'(irq), 32'h1);
        step(1);
        checkOutput("release w1c irq N+2", 32'(irq), 32'h0);

        // W1C landing on the same edge as a new event: the event wins.
        buttons = 3'b010;
        step(25);
        buttons = '0;
        step(17);
        busWrite(32'h14, 32'h2, 4'hF, "w1c collide");
        busRead(32'h14, 32'h2, "collide status");
        checkOutput("collide irq", 32'(irq), 32'h1);
        busWrite(32'h14, 32'h2, 4'hF, "w1c after collide");
        step(1);
        checkOutput("collide cleared irq", 32'(irq), 32'h0);

        begin
            int hold = 0;
            logic [31:0] a;
            for (int c = 0; c < 2000; c++) begin
                if (hold == 0) begin
                    buttons = NB'($urandom);
                    hold = $urandom_range(1, 40);
                end else begin
                    hold--;
                end
                a = ($urandom % 8 == 0) ? BASE + $urandom_range(0, 31) : BASE + 4 * $urandom_range(0, 7);
                applyStimulus($urandom % 4 != 0, 1'($urandom), 1'($urandom), 4'($urandom), a, $urandom);
                @(negedge clk);
                checkOutput("rand ack", 32'(ack), 32'(m_ack));
                checkOutput("rand rdata", rdata, m_rdata);
                checkOutput("rand leds", 32'(leds), m_leds);
                checkOutput("rand irq", 32'(irq), 32'(m_irq));
            end
            idle();
        end

        // Reset during an active strobe with the interrupt asserted.
        buttons = '0;
        step(25);
        busWrite(32'h10, 32'h7, 4'hF, "edge rising");
        busWrite(32'h14, 32'hFFFF_FFFF, 4'hF, "clear all");
        busWrite(32'h0C, 32'h2, 4'hF, "enable bit1");
        busWrite(32'h00, 32'h3C, 4'hF, "leds pre-reset");
        buttons = 3'b010;
        step(20);
        checkOutput("pre-reset irq", 32'(irq), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, BASE + 32'h00, 32'h0);
        reset_n = 1'b0;
        buttons = '0;
        @(negedge clk);
        checkOutput("mid-reset ack", 32'(ack), 32'h0);
        checkOutput("mid-reset irq", 32'(irq), 32'h0);
        checkOutput("mid-reset leds", 32'(leds), 32'h0);
        checkOutput("mid-reset rdata", rdata, 32'h0);
        reset_n = 1'b1;
        idle();
        busRead(32'h00, 32'h0, "post-reset led");
        busRead(32'h04, 32'h0, "post-reset toggle");
        busRead(32'h08, 32'h0, "post-reset button");
        busRead(32'h0C, 32'h0, "post-reset enable");
        busRead(32'h10, 32'h7, "post-reset edge");
        busRead(32'h14, 32'h0, "post-reset status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
